// File: rtl/el2_soc_pkg.sv
// Shared SoC definitions for the interrupt/SysTick block: limits, defaults,
// the SysTick state type and the per-channel pending-bit update rule.
package el2_soc_pkg;

  localparam int IRQ_MAX         = 31;
  localparam int TICK_W_DEF      = 24;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } systick_state_e;

  // Next value of one request bit. A mode change wipes the bit so a stale
  // level or pending edge never leaks across modes; in edge mode a new edge
  // beats a simultaneous acknowledge.
  function automatic logic pend_next(
    input logic edge_mode,
    input logic mode_q,
    input logic rise,
    input logic lvl,
    input logic ack,
    input logic cur
  );
    if (edge_mode != mode_q) return 1'b0;
    if (!edge_mode)          return lvl;
    return rise | (cur & ~ack);
  endfunction

endpackage

// File: rtl/el2_sync.sv
// Multi-flop synchronizer for a vector of asynchronous inputs.
module el2_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/el2_irq_systick.sv
// External IRQ / NMI conditioning and SysTick timer feeding the core PIC,
// timer_int and nmi_int inputs.
module el2_irq_systick
  import el2_soc_pkg::*;
#(
  parameter int NUM_IRQ     = 15,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TICK_W      = TICK_W_DEF
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [NUM_IRQ-1:0] IRQ_EDGE,
  input  logic [NUM_IRQ-1:0] IRQ_ACK,
  input  logic               NMI,
  input  logic               SYSTICK_EN,
  input  logic [TICK_W-1:0]  SYSTICKCLKDIV,
  input  logic               SYSTICK_ACK,
  output logic [NUM_IRQ-1:0] EXTINTSRC_REQ,
  output logic               TIMER_INT,
  output logic               NMI_INT,
  output logic [TICK_W-1:0]  SYSTICK_CNT
);

  localparam logic [2:0]        ARM_DONE = 3'(SYNC_STAGES + 1);
  localparam logic [TICK_W-1:0] CNT_ONE  = TICK_W'(1);

  logic [NUM_IRQ:0]   w_sync_in;
  logic [NUM_IRQ:0]   w_sync_out;
  logic [NUM_IRQ-1:0] w_irq_s;
  logic               w_nmi_s;

  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_req;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_req_nxt;
  logic               r_nmi_prev;
  logic               r_nmi_int;
  logic [2:0]         r_arm_cnt;
  logic               w_armed;

  systick_state_e     r_state;
  systick_state_e     w_state_nxt;
  logic [TICK_W-1:0]  r_cnt;
  logic [TICK_W-1:0]  w_cnt_nxt;
  logic               w_tick;
  logic               r_timer_int;

  assign w_sync_in = {NMI, IRQ};

  el2_sync #(
    .WIDTH  (NUM_IRQ + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_d     (w_sync_in),
    .o_q     (w_sync_out)
  );

  assign w_irq_s = w_sync_out[NUM_IRQ-1:0];
  assign w_nmi_s = w_sync_out[NUM_IRQ];

  // Edge detection stays blind until the synchronizer and the previous-value
  // flop hold post-reset samples, so a source already high at reset release
  // is not mistaken for a fresh edge.
  assign w_armed = (r_arm_cnt == ARM_DONE);
  assign w_rise  = w_irq_s & ~r_irq_prev & {NUM_IRQ{w_armed}};

  always_comb begin
    w_req_nxt = r_req;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_req_nxt[i] = pend_next(IRQ_EDGE[i], r_mode[i], w_rise[i],
                               w_irq_s[i], IRQ_ACK[i], r_req[i]);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_arm_cnt  <= '0;
      r_irq_prev <= '0;
      r_mode     <= '0;
      r_req      <= '0;
      r_nmi_prev <= 1'b0;
      r_nmi_int  <= 1'b0;
    end else begin
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 3'd1;
      r_irq_prev <= w_irq_s;
      r_mode     <= IRQ_EDGE;
      r_req      <= w_req_nxt;
      r_nmi_prev <= w_nmi_s;
      r_nmi_int  <= w_nmi_s & ~r_nmi_prev;
    end
  end

  // SysTick: the registered state gives one load cycle after enabling, and
  // the reload value is only sampled at the reload itself.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tick      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = SYSTICKCLKDIV;
        if (SYSTICK_EN) w_state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (r_cnt == '0) begin
          w_tick    = 1'b1;
          w_cnt_nxt = SYSTICKCLKDIV;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
        if (!SYSTICK_EN) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_timer_int <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_tick)           r_timer_int <= 1'b1;
      else if (SYSTICK_ACK) r_timer_int <= 1'b0;
    end
  end

  assign EXTINTSRC_REQ = r_req;
  assign TIMER_INT     = r_timer_int;
  assign NMI_INT       = r_nmi_int;
  assign SYSTICK_CNT   = r_cnt;

endmodule

// File: tb/tb_el2_irq_systick.sv
// Self-checking bench for el2_irq_systick: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_el2_irq_systick;

  localparam int N  = 15;
  localparam int S  = 2;
  localparam int TW = 24;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [N-1:0]  IRQ, IRQ_EDGE, IRQ_ACK;
  logic          NMI, SYSTICK_EN, SYSTICK_ACK;
  logic [TW-1:0] SYSTICKCLKDIV;
  logic [N-1:0]  EXTINTSRC_REQ;
  logic          TIMER_INT, NMI_INT;
  logic [TW-1:0] SYSTICK_CNT;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  el2_irq_systick #(.NUM_IRQ(N), .SYNC_STAGES(S), .TICK_W(TW)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .IRQ           (IRQ),
    .IRQ_EDGE      (IRQ_EDGE),
    .IRQ_ACK       (IRQ_ACK),
    .NMI           (NMI),
    .SYSTICK_EN    (SYSTICK_EN),
    .SYSTICKCLKDIV (SYSTICKCLKDIV),
    .SYSTICK_ACK   (SYSTICK_ACK),
    .EXTINTSRC_REQ (EXTINTSRC_REQ),
    .TIMER_INT     (TIMER_INT),
    .NMI_INT       (NMI_INT),
    .SYSTICK_CNT   (SYSTICK_CNT)
  );

  // Reference model: pin samples per clock edge since reset release, a
  // per-channel mode memory, and a SysTick expressed as the edge number of
  // the next tick (deadline) rather than a down-counter.
  int            m_n;
  logic [N-1:0]  m_ih [0:S+1];
  logic          m_nh [0:S+1];
  logic [N-1:0]  m_mode, m_req;
  logic          m_nmi, m_timer, m_counting;
  logic [TW-1:0] m_cnt;
  int            m_deadline;

  task automatic model_reset();
    m_n = 0;
    for (int k = 0; k <= S + 1; k++) begin
      m_ih[k] = '0;
      m_nh[k] = 1'b0;
    end
    m_mode = '0; m_req = '0; m_nmi = 1'b0; m_timer = 1'b0;
    m_counting = 1'b0; m_cnt = '0; m_deadline = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] lvl, prv;
    logic tick;
    m_n++;
    for (int k = S + 1; k > 0; k--) begin
      m_ih[k] = m_ih[k-1];
      m_nh[k] = m_nh[k-1];
    end
    m_ih[0] = IRQ;
    m_nh[0] = NMI;
    // Pin value seen S+1 edges late; edges only among post-reset samples.
    lvl = m_ih[S];
    prv = m_ih[S+1];
    for (int i = 0; i < N; i++) begin
      if (IRQ_EDGE[i] !== m_mode[i]) m_req[i] = 1'b0;
      else if (IRQ_EDGE[i]) begin
        if (m_n > S + 1 && lvl[i] && !prv[i]) m_req[i] = 1'b1;
        else if (IRQ_ACK[i])                  m_req[i] = 1'b0;
      end else m_req[i] = lvl[i];
    end
    m_mode = IRQ_EDGE;
    m_nmi  = m_nh[S] & ~m_nh[S+1];
    tick = 1'b0;
    if (!m_counting) begin
      m_cnt      = SYSTICKCLKDIV;
      m_deadline = m_n + int'(SYSTICKCLKDIV) + 1;
    end else if (m_n == m_deadline) begin
      tick       = 1'b1;
      m_cnt      = SYSTICKCLKDIV;
      m_deadline = m_n + int'(SYSTICKCLKDIV) + 1;
    end else begin
      m_cnt = TW'(m_deadline - m_n - 1);
    end
    if (tick)             m_timer = 1'b1;
    else if (SYSTICK_ACK) m_timer = 1'b0;
    m_counting = SYSTICK_EN;
  endtask

  task automatic step();
    model_step();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic do_reset(input logic en, input logic [TW-1:0] div, input logic [N-1:0] edge_m);
    HRESETn = 1'b0;
    IRQ = '0; IRQ_ACK = '0; NMI = 1'b0; SYSTICK_ACK = 1'b0;
    IRQ_EDGE = edge_m; SYSTICK_EN = en; SYSTICKCLKDIV = div;
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b1, TW'(3), '0);
    IRQ = '1; NMI = 1'b1;
    for (int k = 0; k < 6; k++) step();
    #2 HRESETn = 1'b0;
    #1;
    checks++; if (EXTINTSRC_REQ !== '0) begin errors++; $display("FAIL reset_req got %h exp 0", EXTINTSRC_REQ); end
    checks++; if (TIMER_INT !== 1'b0) begin errors++; $display("FAIL reset_timer got %b exp 0", TIMER_INT); end
    checks++; if (NMI_INT !== 1'b0) begin errors++; $display("FAIL reset_nmi got %b exp 0", NMI_INT); end
    checks++; if (SYSTICK_CNT !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", SYSTICK_CNT); end
    @(negedge HCLK);
  endtask

  task automatic test_edge_irq();
    do_reset(1'b0, '0, N'(15'h0008));
    for (int k = 0; k < 5; k++) step();
    IRQ[3] = 1'b1; step();
    IRQ[3] = 1'b0; step();
    checks++; if (EXTINTSRC_REQ[3] !== 1'b0) begin errors++; $display("FAIL edge_early got %b exp 0", EXTINTSRC_REQ[3]); end
    step();
    checks++; if (EXTINTSRC_REQ[3] !== 1'b1) begin errors++; $display("FAIL edge_set got %b exp 1", EXTINTSRC_REQ[3]); end
    for (int k = 0; k < 4; k++) step();
    checks++; if (EXTINTSRC_REQ !== N'(15'h0008)) begin errors++; $display("FAIL edge_hold got %h exp 0008", EXTINTSRC_REQ); end
    IRQ_ACK[3] = 1'b1; step(); IRQ_ACK[3] = 1'b0;
    checks++; if (EXTINTSRC_REQ[3] !== 1'b0) begin errors++; $display("FAIL edge_ack got %b exp 0", EXTINTSRC_REQ[3]); end
    // New edge landing on the same edge as an acknowledge.
    IRQ[3] = 1'b1; step();
    IRQ[3] = 1'b0; step();
    IRQ_ACK[3] = 1'b1; step();
    checks++; if (EXTINTSRC_REQ[3] !== 1'b1) begin errors++; $display("FAIL edge_setwins got %b exp 1", EXTINTSRC_REQ[3]); end
    step(); IRQ_ACK[3] = 1'b0;
    checks++; if (EXTINTSRC_REQ[3] !== 1'b0) begin errors++; $display("FAIL edge_ack2 got %b exp 0", EXTINTSRC_REQ[3]); end
  endtask

  task automatic test_level_irq();
    int hi, first;
    hi = 0; first = 0;
    do_reset(1'b0, '0, '0);
    IRQ_ACK = '1;
    for (int k = 0; k < 5; k++) step();
    for (int k = 1; k <= 22; k++) begin
      IRQ[5] = (k <= 10);
      step();
      checks++; if (EXTINTSRC_REQ !== m_req) begin errors++; $display("FAIL level_model k %0d got %h exp %h", k, EXTINTSRC_REQ, m_req); end
      if (EXTINTSRC_REQ[5]) begin
        hi++;
        if (first == 0) first = k;
      end
    end
    IRQ_ACK = '0;
    checks++; if (hi != 10) begin errors++; $display("FAIL level_width got %0d exp 10", hi); end
    checks++; if (first != 3) begin errors++; $display("FAIL level_delay got %0d exp 3", first); end
  endtask

  task automatic test_systick();
    logic exp_t;
    int first;
    first = 0;
    do_reset(1'b1, TW'(9), '0);
    for (int k = 1; k <= 40; k++) begin
      SYSTICK_ACK = (k == 12 || k == 31);
      step();
      exp_t = (k == 11) || (k >= 21);
      if (TIMER_INT && first == 0) first = k;
      checks++; if (TIMER_INT !== exp_t) begin errors++; $display("FAIL tick_timer k %0d got %b exp %b", k, TIMER_INT, exp_t); end
      checks++; if (SYSTICK_CNT !== m_cnt) begin errors++; $display("FAIL tick_cnt k %0d got %0d exp %0d", k, SYSTICK_CNT, m_cnt); end
    end
    SYSTICK_ACK = 1'b0;
    checks++; if (first != 11) begin errors++; $display("FAIL tick_first got %0d exp 11", first); end
  endtask

  task automatic test_nmi();
    int pulses, first;
    pulses = 0; first = 0;
    do_reset(1'b0, '0, '0);
    for (int k = 0; k < 5; k++) step();
    for (int k = 1; k <= 60; k++) begin
      NMI = (k <= 50);
      step();
      if (NMI_INT) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL nmi_count got %0d exp 1", pulses); end
    checks++; if (first != 3) begin errors++; $display("FAIL nmi_delay got %0d exp 3", first); end
  endtask

  task automatic test_div_change();
    logic exp_t;
    do_reset(1'b1, TW'(9), '0);
    SYSTICK_ACK = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    checks++; if (SYSTICK_CNT !== TW'(6)) begin errors++; $display("FAIL div_cnt6 got %0d exp 6", SYSTICK_CNT); end
    SYSTICKCLKDIV = TW'(4);
    for (int k = 5; k <= 25; k++) begin
      step();
      exp_t = (k == 11) || (k == 16) || (k == 21);
      checks++; if (TIMER_INT !== exp_t) begin errors++; $display("FAIL div_tick k %0d got %b exp %b", k, TIMER_INT, exp_t); end
    end
    SYSTICK_ACK = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, TW'(9), N'(15'h0008));
    IRQ[3] = 1'b1; step();
    IRQ[3] = 1'b0;
    for (int k = 2; k <= 7; k++) step();
    checks++; if (SYSTICK_CNT !== TW'(3) || EXTINTSRC_REQ[3] !== 1'b0) begin errors++; $display("FAIL mid_pre got cnt %0d req %b exp 3 0", SYSTICK_CNT, EXTINTSRC_REQ[3]); end
    // Pulse too early to count (still arming); drive a fresh edge now.
    IRQ[3] = 1'b1; step(); step(); step();
    checks++; if (EXTINTSRC_REQ[3] !== 1'b1) begin errors++; $display("FAIL mid_pend got %b exp 1", EXTINTSRC_REQ[3]); end
    #2 HRESETn = 1'b0;
    #1;
    checks++; if ({EXTINTSRC_REQ, TIMER_INT, NMI_INT} !== '0 || SYSTICK_CNT !== '0) begin errors++; $display("FAIL mid_async got req %h t %b n %b cnt %0d exp 0", EXTINTSRC_REQ, TIMER_INT, NMI_INT, SYSTICK_CNT); end
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (EXTINTSRC_REQ[3] !== 1'b0) begin errors++; $display("FAIL mid_noedge k %0d got %b exp 0", k, EXTINTSRC_REQ[3]); end
    end
    IRQ[3] = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 0) do_reset(1'b1, TW'($urandom_range(0, 12)), N'($urandom));
      IRQ = IRQ ^ N'($urandom & $urandom);
      IRQ_ACK = N'($urandom & $urandom);
      if ($urandom_range(0, 49) == 0) IRQ_EDGE = N'($urandom);
      if ($urandom_range(0, 7) == 0) NMI = ~NMI;
      if ($urandom_range(0, 99) == 0) SYSTICK_EN = ~SYSTICK_EN;
      if ($urandom_range(0, 29) == 0) SYSTICKCLKDIV = TW'($urandom_range(0, 12));
      SYSTICK_ACK = ($urandom_range(0, 3) == 0);
      step();
      checks++; if (EXTINTSRC_REQ !== m_req) begin errors++; $display("FAIL rnd_req c %0d got %h exp %h", c, EXTINTSRC_REQ, m_req); end
      checks++; if (TIMER_INT !== m_timer) begin errors++; $display("FAIL rnd_timer c %0d got %b exp %b", c, TIMER_INT, m_timer); end
      checks++; if (NMI_INT !== m_nmi) begin errors++; $display("FAIL rnd_nmi c %0d got %b exp %b", c, NMI_INT, m_nmi); end
      checks++; if (SYSTICK_CNT !== m_cnt) begin errors++; $display("FAIL rnd_cnt c %0d got %0d exp %0d", c, SYSTICK_CNT, m_cnt); end
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    IRQ = '0; IRQ_EDGE = '0; IRQ_ACK = '0; NMI = 1'b0;
    SYSTICK_EN = 1'b0; SYSTICKCLKDIV = '0; SYSTICK_ACK = 1'b0;
    model_reset();
    @(negedge HCLK);
    test_reset();
    test_edge_irq();
    test_level_irq();
    test_systick();
    test_nmi();
    test_div_change();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
